// File: rtl/melody_sequencer.sv
// Note sequencer: fetches packed note codes from a synchronous song ROM, plays each note as a
// silent gap followed by a timed sounding phase, and grades player lateness in learn mode.
module melody_sequencer #(
    parameter int              NOTE_W   = 6,
    parameter int              ADDR_W   = 10,
    parameter longint unsigned UNIT_CYC = 6250000,
    parameter longint unsigned GAP_CYC  = 2000000,
    parameter int              MISS_W   = 32,
    parameter longint unsigned GRADE_A  = 900000000,
    parameter longint unsigned GRADE_B  = 2000000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    input  logic              learn,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] song_base,
    input  logic [ADDR_W-1:0] song_len,
    input  logic              key_match,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_data,
    output logic [NOTE_W-3:0] pitch,
    output logic              sounding,
    output logic [NOTE_W-3:0] expect_pitch,
    output logic [ADDR_W-1:0] index,
    output logic              busy,
    output logic              done,
    output logic [MISS_W-1:0] miss_cyc,
    output logic [1:0]        grade,
    output logic [2:0]        fsm_state
);

    localparam int          PW     = NOTE_W - 2;
    localparam logic [31:0] UNIT32 = 32'(UNIT_CYC);
    localparam logic [31:0] GAP32  = 32'(GAP_CYC);

    if ((UNIT_CYC << 3) > 64'hFFFF_FFFF) begin : g_unit_check
        $error("UNIT_CYC << 3 does not fit in 32 bits");
    end
    if (GAP_CYC == 0) begin : g_gap_check
        $error("GAP_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_GAP, S_WAIT_KEY, S_PLAY, S_DONE
    } state_t;

    state_t            state;
    logic              learn_r;
    logic              loop_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] len_r;
    logic [NOTE_W-1:0] note_r;
    logic [31:0]       cnt;
    logic              snd_r;

    logic [PW-1:0]     note_pitch;
    logic [1:0]        dclass;
    logic [31:0]       play_len;
    logic              gap_last;
    logic              play_last;
    logic [ADDR_W-1:0] idx_next;
    logic              end_song;
    logic [MISS_W-1:0] miss_inc;

    assign note_pitch = note_r[PW-1:0];
    assign dclass     = note_r[NOTE_W-1:NOTE_W-2];
    assign play_len   = UNIT32 << dclass;
    assign gap_last   = (cnt == GAP32 - 32'd1);
    assign play_last  = (cnt == play_len - 32'd1);
    assign idx_next   = index + 1'b1;
    assign end_song   = (idx_next == len_r);
    assign miss_inc   = (&miss_cyc) ? miss_cyc : miss_cyc + 1'b1;

    // Pause mutes the buzzer immediately while the pitch stays visible on the display.
    assign sounding  = snd_r & ~pause;
    assign fsm_state = state;

    function automatic logic [1:0] grade_of(input logic lrn, input logic [MISS_W-1:0] m);
        if (!lrn)                 return 2'd2;
        else if (64'(m) < GRADE_A) return 2'd2;
        else if (64'(m) < GRADE_B) return 2'd1;
        else                       return 2'd0;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            learn_r      <= 1'b0;
            loop_r       <= 1'b0;
            base_r       <= '0;
            len_r        <= '0;
            note_r       <= '0;
            cnt          <= '0;
            snd_r        <= 1'b0;
            rom_addr     <= '0;
            pitch        <= '0;
            expect_pitch <= '0;
            index        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            miss_cyc     <= '0;
            grade        <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state        <= S_IDLE;
                busy         <= 1'b0;
                snd_r        <= 1'b0;
                pitch        <= '0;
                expect_pitch <= '0;
            end else if (!pause) begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            index    <= '0;
                            miss_cyc <= '0;
                            grade    <= '0;
                            learn_r  <= learn;
                            loop_r   <= loop_en;
                            base_r   <= song_base;
                            len_r    <= song_len;
                            if (song_len == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                grade <= grade_of(learn, '0);
                            end else begin
                                state    <= S_FETCH;
                                busy     <= 1'b1;
                                rom_addr <= song_base;
                            end
                        end
                    end
                    S_FETCH: state <= S_LOAD;
                    S_LOAD: begin
                        note_r <= rom_data;
                        cnt    <= '0;
                        state  <= S_GAP;
                    end
                    S_GAP: begin
                        if (gap_last) begin
                            cnt <= '0;
                            if (learn_r && note_pitch != '0) begin
                                state        <= S_WAIT_KEY;
                                expect_pitch <= note_pitch;
                            end else begin
                                state <= S_PLAY;
                                pitch <= note_pitch;
                                snd_r <= (note_pitch != '0);
                            end
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_WAIT_KEY: begin
                        // The matching cycle itself is not counted as late.
                        if (key_match) begin
                            state        <= S_PLAY;
                            expect_pitch <= '0;
                            pitch        <= note_pitch;
                            snd_r        <= 1'b1;
                        end else begin
                            miss_cyc <= miss_inc;
                        end
                    end
                    S_PLAY: begin
                        if (play_last) begin
                            pitch <= '0;
                            snd_r <= 1'b0;
                            cnt   <= '0;
                            if (end_song) begin
                                if (loop_r && !learn_r) begin
                                    index    <= '0;
                                    state    <= S_FETCH;
                                    rom_addr <= base_r;
                                end else begin
                                    index <= idx_next;
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    grade <= grade_of(learn_r, miss_cyc);
                                end
                            end else begin
                                index    <= idx_next;
                                state    <= S_FETCH;
                                rom_addr <= base_r + idx_next;
                            end
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: stimulus pushes expected events into queues and a
// monitor pops and compares them as the sequencer produces sounding runs, done pulses and fetches.
module tb_melody_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort, pause, learn, loop_en, key_match;
    logic [9:0] song_base, song_len;
    logic [9:0] rom_addr;
    logic [5:0] rom_data;
    logic [3:0] pitch, expect_pitch;
    logic       sounding, busy, done;
    logic [9:0] index;
    logic [31:0] miss_cyc;
    logic [1:0] grade;
    logic [2:0] fsm_state;

    logic [5:0] rom [0:1023];

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_run_q[$];
    logic [31:0] exp_done_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_idx_q[$];
    logic [31:0] exp_key_q[$];

    bit run_en = 1'b0, addr_en = 1'b0, idx_en = 1'b0, chk_gap = 1'b0;
    int idx_events = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    melody_sequencer #(
        .NOTE_W(6), .ADDR_W(10), .UNIT_CYC(4), .GAP_CYC(2),
        .MISS_W(32), .GRADE_A(15), .GRADE_B(30)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
        .learn(learn), .loop_en(loop_en), .song_base(song_base), .song_len(song_len),
        .key_match(key_match), .rom_addr(rom_addr), .rom_data(rom_data),
        .pitch(pitch), .sounding(sounding), .expect_pitch(expect_pitch), .index(index),
        .busy(busy), .done(done), .miss_cyc(miss_cyc), .grade(grade), .fsm_state(fsm_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event 0x%0h, expected none", name, act);
    endtask

    function automatic logic [31:0] pk_done(input logic [1:0] g, input logic [15:0] m,
                                            input logic [9:0] i);
        return {4'd0, g, m, i};
    endfunction

    function automatic logic [31:0] pk_run(input int span, input int hi);
        return {16'(span), 16'(hi)};
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    int         cyc = 0, last_high = -10, run_first = 0, run_hi = 0;
    bit         in_run = 1'b0;
    logic [9:0] prev_addr = '0, prev_idx = '0;
    logic [3:0] prev_key = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!run_en) begin
                in_run = 1'b0;
            end else if (sounding) begin
                if (!in_run) begin
                    in_run    = 1'b1;
                    run_hi    = 0;
                    run_first = cyc;
                end
                run_hi++;
            end else if (in_run && !pause) begin
                in_run = 1'b0;
                if (exp_run_q.size() == 0) unexpected("run", pk_run(last_high - run_first + 1, run_hi));
                else check("run", pk_run(last_high - run_first + 1, run_hi), exp_run_q.pop_front());
            end
            if (done) begin
                if (exp_done_q.size() == 0) unexpected("done", pk_done(grade, miss_cyc[15:0], index));
                else check("done", pk_done(grade, miss_cyc[15:0], index), exp_done_q.pop_front());
                if (chk_gap) check("done_gap", 32'(cyc - last_high), 32'd1);
            end
            if (sounding) last_high = cyc;
            if (addr_en && rom_addr != prev_addr) begin
                if (exp_addr_q.size() == 0) unexpected("rom_addr", 32'(rom_addr));
                else check("rom_addr", 32'(rom_addr), exp_addr_q.pop_front());
            end
            prev_addr = rom_addr;
            if (idx_en && index != prev_idx) begin
                idx_events++;
                if (exp_idx_q.size() == 0) unexpected("index", 32'(index));
                else check("index", 32'(index), exp_idx_q.pop_front());
            end
            prev_idx = index;
            if (expect_pitch != 0 && prev_key == 0) begin
                if (exp_key_q.size() == 0) unexpected("expect", 32'(expect_pitch));
                else check("expect", 32'(expect_pitch), exp_key_q.pop_front());
            end
            prev_key = expect_pitch;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_song(input logic [9:0] base, input logic [9:0] len,
                              input logic lrn, input logic lp);
        @(negedge clk);
        song_base = base;
        song_len  = len;
        learn     = lrn;
        loop_en   = lp;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < budget);
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_sounding(input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!sounding && n < budget);
        check("sound_timeout", 32'(sounding), 32'd1);
    endtask

    task automatic wait_key_state(input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (expect_pitch == 0 && n < budget);
        check("wait_key_timeout", 32'(expect_pitch != 0), 32'd1);
    endtask

    task automatic drain(input string name);
        check(name, 32'(exp_run_q.size() + exp_done_q.size() + exp_addr_q.size()
                        + exp_idx_q.size() + exp_key_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"}, {pitch, expect_pitch, sounding, busy, done, grade, 10'd0, rom_addr},
              32'd0);
        check({name, "_index"}, 32'(index), 32'd0);
        check({name, "_miss"}, miss_cyc, 32'd0);
        check({name, "_state"}, 32'(fsm_state), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 6'h00;
        rom[200]  = 6'h13;
        rom[100]  = 6'h21; rom[101] = 6'h10; rom[102] = 6'h05;
        rom[300]  = 6'h03; rom[301] = 6'h12;
        rom[400]  = 6'h21;
        rom[1023] = 6'h01; rom[0]   = 6'h00;
        rom[500]  = 6'h01; rom[501] = 6'h12;

        reset = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
        learn = 1'b0; loop_en = 1'b0; key_match = 1'b0;
        song_base = '0; song_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("por");
        @(negedge clk);
        reset = 1'b1;

        // Reset in the middle of a sounding note, then a clean replay from index 0.
        start_song(10'd200, 10'd1, 1'b0, 1'b0);
        wait_sounding(50);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        reset  = 1'b1;
        run_en = 1'b1;
        exp_run_q.push_back(pk_run(8, 8));
        exp_done_q.push_back(pk_done(2'd2, 16'd0, 10'd1));
        start_song(10'd200, 10'd1, 1'b0, 1'b0);
        check("restart_addr", 32'(rom_addr), 32'd200);
        check("restart_index", 32'(index), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        wait_idle(100);
        drain("drain_t1");

        // Auto playback of quarter pitch1, eighth rest, sixteenth pitch5.
        @(negedge clk);
        addr_en = 1'b1;
        chk_gap = 1'b1;
        exp_addr_q.push_back(32'd100);
        exp_addr_q.push_back(32'd101);
        exp_addr_q.push_back(32'd102);
        exp_run_q.push_back(pk_run(16, 16));
        exp_run_q.push_back(pk_run(4, 4));
        exp_done_q.push_back(pk_done(2'd2, 16'd0, 10'd3));
        start_song(10'd100, 10'd3, 1'b0, 1'b0);
        wait_idle(200);
        drain("drain_t2");
        @(negedge clk);
        addr_en = 1'b0;
        chk_gap = 1'b0;

        // Learn mode: a key press during the gap is ignored; each note answered 10 cycles late.
        exp_key_q.push_back(32'd3);
        exp_key_q.push_back(32'd2);
        exp_run_q.push_back(pk_run(4, 4));
        exp_run_q.push_back(pk_run(8, 8));
        exp_done_q.push_back(pk_done(2'd1, 16'd20, 10'd2));
        start_song(10'd300, 10'd2, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        key_match = 1'b1;
        @(negedge clk);
        key_match = 1'b0;
        for (int n = 0; n < 2; n++) begin
            wait_key_state(50);
            repeat (11) @(negedge clk);
            key_match = 1'b1;
            @(negedge clk);
            key_match = 1'b0;
        end
        wait_idle(200);
        check("learn_grade", 32'(grade), 32'd1);
        drain("drain_t3");

        // Seven-cycle pause in the middle of a quarter note.
        exp_run_q.push_back(pk_run(23, 16));
        exp_done_q.push_back(pk_done(2'd2, 16'd0, 10'd1));
        start_song(10'd400, 10'd1, 1'b0, 1'b0);
        wait_sounding(50);
        repeat (4) @(negedge clk);
        pause = 1'b1;
        @(posedge clk);
        #1;
        check("pause_mute", 32'(sounding), 32'd0);
        check("pause_pitch", 32'(pitch), 32'd1);
        repeat (7) @(negedge clk);
        pause = 1'b0;
        wait_idle(200);
        drain("drain_t4");

        // Empty song, then a song wrapping from the top of the ROM to address 0.
        @(negedge clk);
        addr_en = 1'b1;
        exp_done_q.push_back(pk_done(2'd2, 16'd0, 10'd0));
        start_song(10'd7, 10'd0, 1'b0, 1'b0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd0);
        exp_addr_q.push_back(32'd1023);
        exp_addr_q.push_back(32'd0);
        exp_run_q.push_back(pk_run(4, 4));
        exp_done_q.push_back(pk_done(2'd2, 16'd0, 10'd2));
        start_song(10'd1023, 10'd2, 1'b0, 1'b0);
        wait_idle(200);
        drain("drain_t5");
        @(negedge clk);
        addr_en = 1'b0;

        // Looping playback, stopped by abort.
        run_en     = 1'b0;
        idx_en     = 1'b1;
        idx_events = 0;
        exp_idx_q.push_back(32'd0);
        exp_idx_q.push_back(32'd1);
        exp_idx_q.push_back(32'd0);
        exp_idx_q.push_back(32'd1);
        start_song(10'd500, 10'd2, 1'b0, 1'b1);
        begin
            int n = 0;
            while (idx_events < 4 && n < 300) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("loop_timeout", 32'(idx_events >= 4), 32'd1);
        end
        wait_sounding(50);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sound", 32'(sounding), 32'd0);
        check("abort_index", 32'(index), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        drain("drain_t6");
        idx_en = 1'b0;

        // Start and abort together: abort wins.
        @(negedge clk);
        song_len = 10'd1;
        start    = 1'b1;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drain("drain_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
